// File: rtl/input_debouncer.sv
// Two-channel synchronizer + debouncer producing stable registered levels a/b.
// Optional DEBOUNCE_EDGE_EN adds one-cycle rise/fall pulses per channel.
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
`endif
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic SINGLE = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } state_e;

    logic [1:0] raw_c;
    logic [1:0] lvl_c;
    logic [1:0] rise_c;
    logic [1:0] fall_c;

    assign raw_c = {b_raw, a_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        state_e                 state_q;
        logic [CW-1:0]          cnt_q;
        logic                   lvl_q;
        logic                   s_c;
        logic                   go_high_c;
        logic                   go_low_c;

        assign s_c = sync_q[SYNC_STAGES-1];

        // A qualified change: the final stable cycle of a check, or the first
        // differing cycle when a single stable cycle is enough.
        assign go_high_c = s_c && (((state_q == CHK_HIGH) && (cnt_q == CNT_LAST)) ||
                                   ((state_q == LOW) && SINGLE));
        assign go_low_c  = !s_c && (((state_q == CHK_LOW) && (cnt_q == CNT_LAST)) ||
                                    ((state_q == HIGH) && SINGLE));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_c[ch]};
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= LOW;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
            end else if (go_high_c) begin
                state_q <= HIGH;
                cnt_q   <= '0;
                lvl_q   <= 1'b1;
            end else if (go_low_c) begin
                state_q <= LOW;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
            end else begin
                case (state_q)
                    LOW: begin
                        if (s_c) begin
                            state_q <= CHK_HIGH;
                            cnt_q   <= CW'(1);
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    CHK_HIGH: begin
                        if (!s_c) begin
                            state_q <= LOW;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                    HIGH: begin
                        if (!s_c) begin
                            state_q <= CHK_LOW;
                            cnt_q   <= CW'(1);
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    CHK_LOW: begin
                        if (s_c) begin
                            state_q <= HIGH;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign lvl_c[ch] = lvl_q;

`ifdef DEBOUNCE_EDGE_EN
        logic rise_q;
        logic fall_q;

        // Pulses register alongside the level so they line up with its change.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= go_high_c;
                fall_q <= go_low_c;
            end
        end

        assign rise_c[ch] = rise_q;
        assign fall_c[ch] = fall_q;
`else
        assign rise_c[ch] = 1'b0;
        assign fall_c[ch] = 1'b0;
`endif
    end

    assign a = lvl_c[0];
    assign b = lvl_c[1];

`ifdef DEBOUNCE_EDGE_EN
    assign a_rise = rise_c[0];
    assign a_fall = fall_c[0];
    assign b_rise = rise_c[1];
    assign b_fall = fall_c[1];
`else
    logic unused_c;
    assign unused_c = ^{rise_c, fall_c};
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus random raw toggling,
// checked against a "last N synced samples agree" reference model.
module tb_input_debouncer;

    localparam int unsigned STABLE = 4;
    localparam int unsigned SYNC   = 2;

    logic clk = 1'b0;
    logic rst;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
`ifdef DEBOUNCE_EDGE_EN
    logic a_rise, a_fall, b_rise, b_fall;
`endif

    int n_vec = 0;
    int n_err = 0;

    bit m_out  [2];
    bit m_rise [2];
    bit m_fall [2];
    bit rawh   [2][$];
    bit sh     [2][$];

    always #5 clk = ~clk;

    input_debouncer #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst   (rst),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a     (a),
        .b     (b)
`ifdef DEBOUNCE_EDGE_EN
        ,
        .a_rise(a_rise),
        .a_fall(a_fall),
        .b_rise(b_rise),
        .b_fall(b_fall)
`endif
    );

    function automatic void model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_out[ch]  = 1'b0;
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            rawh[ch].delete();
            sh[ch].delete();
            for (int i = 0; i < int'(SYNC); i++) rawh[ch].push_back(1'b0);
            for (int i = 0; i < int'(STABLE); i++) sh[ch].push_back(1'b0);
        end
    endfunction

    // Output flips once the last STABLE synced samples all disagree with it.
    function automatic void model_edge(input bit ra, input bit rb);
        bit raw [2];
        bit s;
        bit agree;
        raw[0] = ra;
        raw[1] = rb;
        for (int ch = 0; ch < 2; ch++) begin
            s = rawh[ch].pop_front();
            rawh[ch].push_back(raw[ch]);
            sh[ch].push_back(s);
            void'(sh[ch].pop_front());
            agree = 1'b1;
            foreach (sh[ch][i]) if (sh[ch][i] == m_out[ch]) agree = 1'b0;
            m_rise[ch] = agree && !m_out[ch];
            m_fall[ch] = agree && m_out[ch];
            if (agree) m_out[ch] = !m_out[ch];
        end
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a", a, m_out[0]);
        chk("b", b, m_out[1]);
`ifdef DEBOUNCE_EDGE_EN
        chk("a_rise", a_rise, m_rise[0]);
        chk("a_fall", a_fall, m_fall[0]);
        chk("b_rise", b_rise, m_rise[1]);
        chk("b_fall", b_fall, m_fall[1]);
`endif
    endtask

    // Called at a negedge; drives raw, steps through one rising edge, checks at next negedge.
    task automatic cycle(input bit ra, input bit rb);
        a_raw = ra;
        b_raw = rb;
        @(posedge clk);
        model_edge(ra, rb);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input bit ra, input bit rb, input int n);
        for (int i = 0; i < n; i++) cycle(ra, rb);
    endtask

    // Async reset applied between edges; outputs must clear before any edge.
    task automatic do_reset(input bit ra, input bit rb);
        #2 rst = 1'b1;
        #1;
        chk("rst_a", a, 1'b0);
        chk("rst_b", b, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
        chk("rst_pulses", a_rise | a_fall | b_rise | b_fall, 1'b0);
`endif
        model_reset();
        @(negedge clk);
        a_raw = ra;
        b_raw = rb;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit ra, rb;
        rst   = 1'b1;
        a_raw = 1'b0;
        b_raw = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Reset with both raw high, then exact re-qualification latency
        hold(1, 1, 8);
        chk("s1_high_a", a, 1'b1);
        do_reset(1, 1);
        for (int i = 1; i <= 6; i++) begin
            cycle(1, 1);
            if (i == 5) chk("lat_not_before", a, 1'b0);
            if (i == 6) chk("lat_at_6", a, 1'b1);
        end

        // Clean press on A, then B; downstream AND of the two
        hold(0, 0, 8);
        hold(1, 0, 8);
        chk("s2_and_low", a & b, 1'b0);
        hold(1, 1, 8);
        chk("s2_and_high", a & b, 1'b1);

        // Release of A and a short low glitch
        hold(0, 1, 8);
        chk("s4_released", a, 1'b0);
        hold(1, 1, 8);
        hold(0, 1, 3);
        hold(1, 1, 8);
        chk("s4_glitch_kept", a, 1'b1);

        // Bounce on A must never reach the output
        hold(0, 0, 8);
        hold(1, 0, 3);
        hold(0, 0, 1);
        hold(1, 0, 3);
        hold(0, 0, 6);
        chk("s3_bounce", a, 1'b0);

        // Reset in the middle of a check
        hold(1, 1, 3);
        do_reset(1, 1);
        hold(1, 1, 7);

        // Simultaneous press
        hold(0, 0, 8);
        hold(1, 1, 8);

        // Random toggling with occasional resets
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) ra = !ra;
            if ($urandom_range(0, 3) == 0) rb = !rb;
            if ($urandom_range(0, 7) == 0) hold(ra, rb, int'($urandom_range(3, 8)));
            if ($urandom_range(0, 149) == 0) do_reset(ra, rb);
            else cycle(ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
